// File: rtl/gf2n_pow_seq_if.sv
// Handshake bundle for the GF(2^N) exponentiation engine.
// The master side supplies operands and consumes results; the slave side is the engine.
interface gf2n_pow_seq_if #(
    parameter int N  = 6,
    parameter int EW = 6
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  x;
    logic [EW-1:0] e;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  y;
    logic          busy;

    modport master (
        output in_valid, x, e, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  in_valid, x, e, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface

// File: rtl/gf2n_pow_seq.sv
// Constant-time sequential exponentiation y = x^e in GF(2^N), polynomial basis.
// Left-to-right square-and-multiply: one exponent bit per clock, always EW clocks,
// regardless of x or e. e = 2^N-2 gives the field inverse.
module gf2n_pow_seq #(
    parameter int         N    = 6,
    parameter logic [N:0] POLY = 7'h43,
    parameter int         EW   = 6
) (
    input  logic          clk,
    input  logic          rst,
    gf2n_pow_seq_if.slave io_bus
);

    localparam int PW = 2 * N - 1;
    localparam int CW = (EW > 1) ? $clog2(EW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [N-1:0]  r_acc;
    logic [N-1:0]  r_xr;
    logic [EW-1:0] r_er;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_y;

    logic [N-1:0]  w_sq;
    logic [N-1:0]  w_sqm;
    logic [N-1:0]  w_step;
    logic          w_ebit;
    logic          w_last;

    // Carry-less NxN product followed by reduction modulo POLY, top bit first so
    // each fold can only disturb lower bits that are reduced later.
    function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) begin
            if (b[i]) begin
                p = p ^ (PW'(a) << i);
            end
        end
        for (int k = PW - 1; k >= N; k--) begin
            if (p[k]) begin
                p = p ^ (PW'(POLY) << (k - N));
            end
        end
        return p[N-1:0];
    endfunction

    // Square, then conditionally multiply by the base, chained in one cycle.
    always_comb begin
        w_ebit = r_er[r_cnt];
        w_last = (r_cnt == '0);
        w_sq   = gf_mul(r_acc, r_acc);
        w_sqm  = gf_mul(w_sq, r_xr);
        w_step = w_ebit ? w_sqm : w_sq;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; in_ready/busy/out_valid are pure state decodes.
    always_comb begin
        w_state_nxt      = r_state;
        io_bus.in_ready  = 1'b0;
        io_bus.busy      = 1'b0;
        io_bus.out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                io_bus.in_ready = 1'b1;
                if (io_bus.in_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                io_bus.busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                io_bus.out_valid = 1'b1;
                if (io_bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, per-bit accumulator update and result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_xr  <= '0;
            r_er  <= '0;
            r_cnt <= '0;
            r_y   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_bus.in_valid) begin
                        r_xr  <= io_bus.x;
                        r_er  <= io_bus.e;
                        r_acc <= N'(1);
                        r_cnt <= CW'(EW - 1);
                    end
                end
                RUN: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_y <= w_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_bus.y = r_y;

endmodule

// File: tb/tb_gf2n_pow_seq.sv
// Directed bench for gf2n_pow_seq: default GF(2^6) instance plus an AES-field
// GF(2^8) instance, checked against hand values and a bitwise reference model.
module tb_gf2n_pow_seq;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    gf2n_pow_seq_if #(.N(6), .EW(6)) ifa ();
    gf2n_pow_seq_if #(.N(8), .EW(8)) ifb ();

    gf2n_pow_seq #(.N(6), .POLY(7'h43), .EW(6)) dut_a (
        .clk    (clk),
        .rst    (rst),
        .io_bus (ifa.slave)
    );

    gf2n_pow_seq #(.N(8), .POLY(9'h11B), .EW(8)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .io_bus (ifb.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Shift-and-add multiply with reduction after every shift.
    function automatic int ref_mul(input int n, input int poly, input int a, input int b);
        int r = 0;
        int aa = a;
        for (int i = 0; i < n; i++) begin
            if (((b >> i) & 1) != 0) r = r ^ aa;
            aa = aa << 1;
            if (((aa >> n) & 1) != 0) aa = aa ^ poly;
        end
        return r;
    endfunction

    // Exponent by repeated multiplication; 0^0 = 1 falls out naturally.
    function automatic int ref_pow(input int n, input int poly, input int x, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = ref_mul(n, poly, r, x);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input int x, input int e);
        ifa.x        = 6'(x);
        ifa.e        = 6'(e);
        ifa.in_valid = 1'b1;
        tick();
        ifa.in_valid = 1'b0;
    endtask

    task automatic start_b(input int x, input int e);
        ifb.x        = 8'(x);
        ifb.e        = 8'(e);
        ifb.in_valid = 1'b1;
        tick();
        ifb.in_valid = 1'b0;
    endtask

    // Edges after the accept edge until out_valid is seen, and busy cycles seen.
    task automatic wait_a(output int lat, output int run);
        lat = 0;
        run = 0;
        while (!ifa.out_valid && lat < 40) begin
            if (ifa.busy) run++;
            tick();
            lat++;
        end
    endtask

    task automatic wait_b(output int lat, output int run);
        lat = 0;
        run = 0;
        while (!ifb.out_valid && lat < 40) begin
            if (ifb.busy) run++;
            tick();
            lat++;
        end
    endtask

    task automatic op_a(input string tag, input int x, input int e, input int exp_y);
        int lat, run;
        start_a(x, e);
        wait_a(lat, run);
        check({tag, "_lat"}, 32'(lat), 32'd6);
        check({tag, "_y"}, 32'(ifa.y), 32'(exp_y));
        tick();
    endtask

    task automatic op_b(input string tag, input int x, input int e, input int exp_y);
        int lat, run;
        start_b(x, e);
        wait_b(lat, run);
        check({tag, "_lat"}, 32'(lat), 32'd8);
        check({tag, "_y"}, 32'(ifb.y), 32'(exp_y));
        tick();
    endtask

    initial begin
        int lat, run, xv, ev, yv;

        rst           = 1'b1;
        ifa.in_valid  = 1'b0;
        ifa.x         = '0;
        ifa.e         = '0;
        ifa.out_ready = 1'b1;
        ifb.in_valid  = 1'b0;
        ifb.x         = '0;
        ifb.e         = '0;
        ifb.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready", 32'(ifa.in_ready), 32'd1);
        check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
        check("rst_busy", 32'(ifa.busy), 32'd0);
        check("rst_y", 32'(ifa.y), 32'd0);
        check("rst_b_in_ready", 32'(ifb.in_ready), 32'd1);
        check("rst_b_y", 32'(ifb.y), 32'd0);

        // alpha^52 = alpha^4+alpha^2+1; out_valid arrives in the 7th cycle after accept.
        start_a(2, 52);
        check("run_in_ready", 32'(ifa.in_ready), 32'd0);
        wait_a(lat, run);
        check("p52_lat", 32'(lat), 32'd6);
        check("p52_busy_cycles", 32'(run), 32'd6);
        check("p52_y", 32'(ifa.y), 32'h15);
        check("p52_busy_done", 32'(ifa.busy), 32'd0);
        tick();
        check("p52_consumed", 32'(ifa.out_valid), 32'd0);
        check("p52_idle_ready", 32'(ifa.in_ready), 32'd1);

        op_a("inv2", 2, 62, 'h21);
        op_a("p63", 2, 63, 'h01);
        op_a("zero_pow0", 0, 0, 'h01);
        op_a("zero_pow52", 0, 52, 'h00);
        op_a("one_pow63", 1, 63, 'h01);

        // Inversion sweep over every nonzero element.
        for (int i = 1; i < 64; i++) begin
            start_a(i, 62);
            wait_a(lat, run);
            yv = int'(ifa.y);
            check($sformatf("sweep_x%0d_inv", i), 32'(ref_mul(6, 'h43, i, yv)), 32'd1);
            check($sformatf("sweep_x%0d_ref", i), 32'(yv), 32'(ref_pow(6, 'h43, i, 62)));
            tick();
        end

        // Backpressure with in_valid held high through RUN and DONE.
        ifa.out_ready = 1'b0;
        start_a(2, 52);
        ifa.x        = 6'h3F;
        ifa.e        = 6'd1;
        ifa.in_valid = 1'b1;
        wait_a(lat, run);
        check("bp_lat", 32'(lat), 32'd6);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_hold%0d_y", i), 32'(ifa.y), 32'h15);
            check($sformatf("bp_hold%0d_in_ready", i), 32'(ifa.in_ready), 32'd0);
            check($sformatf("bp_hold%0d_out_valid", i), 32'(ifa.out_valid), 32'd1);
            tick();
        end
        ifa.out_ready = 1'b1;
        tick();
        check("bp_release_ready", 32'(ifa.in_ready), 32'd1);
        check("bp_release_busy", 32'(ifa.busy), 32'd0);
        tick();
        ifa.in_valid = 1'b0;
        check("bp_next_accept_busy", 32'(ifa.busy), 32'd1);
        wait_a(lat, run);
        check("bp_next_y", 32'(ifa.y), 32'h3F);
        tick();

        // Abort in the third RUN cycle.
        start_a(2, 52);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 32'(ifa.in_ready), 32'd1);
        check("abort_busy", 32'(ifa.busy), 32'd0);
        check("abort_out_valid", 32'(ifa.out_valid), 32'd0);
        check("abort_y", 32'(ifa.y), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check("abort_no_result", 32'(ifa.out_valid), 32'd0);
        op_a("after_abort", 3, 1, 'h03);

        // AES field instance.
        op_b("aes_inv53", 'h53, 254, 'hCA);
        op_b("aes_zero_pow0", 0, 0, 'h01);
        for (int i = 0; i < 8; i++) begin
            xv = int'($urandom_range(0, 255));
            ev = int'($urandom_range(0, 255));
            op_b($sformatf("aes_rnd%0d", i), xv, ev, ref_pow(8, 'h11B, xv, ev));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
